// File: rtl/psum_pkg.sv
// Shared types and constants for the partial-sum accumulator.
//
// Contents:
//   psum_state_e : accumulator FSM states (StIdle, StAccum)
//   cnt_width()  : width of a term counter able to hold 0..max_terms
//   Def*         : default widths and group size
package psum_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } psum_state_e;

  localparam int unsigned DefDwidth   = 8;
  localparam int unsigned DefOwidth   = 8;
  localparam int unsigned DefMaxTerms = 8;

  function automatic int unsigned cnt_width(input int unsigned max_terms);
    return $clog2(max_terms + 1);
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Combinational adder: OWIDTH-bit accumulator plus zero-extended DWIDTH-bit term.
//
// Configuration macro: PSUM_SAT_EN
//   defined   : sum clamps at 2^OWIDTH-1 on overflow
//   undefined : sum wraps modulo 2^OWIDTH
//
// Ports:
//   a_i   [OWIDTH-1:0] accumulator operand
//   b_i   [DWIDTH-1:0] partial-sum operand (unsigned)
//   sum_o [OWIDTH-1:0] result (wrapped or clamped)
//   ovf_o              carry out of the OWIDTH-bit addition
module psum_sat_add #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned OWIDTH = 8
) (
  input  logic [OWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  output logic [OWIDTH-1:0] sum_o,
  output logic              ovf_o
);

  logic [OWIDTH:0] full_sum;

  assign full_sum = {1'b0, a_i} + {{(OWIDTH - DWIDTH + 1){1'b0}}, b_i};
  assign ovf_o    = full_sum[OWIDTH];

`ifdef PSUM_SAT_EN
  assign sum_o = ovf_o ? {OWIDTH{1'b1}} : full_sum[OWIDTH-1:0];
`else
  assign sum_o = full_sum[OWIDTH-1:0];
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum reducer: adds groups of 1..MAX_TERMS consecutive input terms and emits
// each group sum with its term count over a valid/ready output.
//
// Configuration macro: PSUM_SAT_EN
//   defined   : additions saturate; extra output out_sat flags a clamped group
//   undefined : additions wrap; out_sat does not exist
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cfg_terms             group size, sampled on a group's first term (0 -> 1, clamped)
//   in_valid/in_ready     input handshake, in_data is the partial sum
//   flush                 close the current group early
//   out_valid/out_ready   output handshake
//   out_data, out_count   group sum and number of terms in it
//   out_sat               (PSUM_SAT_EN only) group saturated
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int unsigned  DWIDTH    = DefDwidth,
  parameter int unsigned  OWIDTH    = DefOwidth,
  parameter int unsigned  MAX_TERMS = DefMaxTerms,
  localparam int unsigned CW        = cnt_width(MAX_TERMS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CW-1:0]     cfg_terms,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OWIDTH-1:0] out_data,
`ifdef PSUM_SAT_EN
  output logic              out_sat,
`endif
  output logic [CW-1:0]     out_count
);

  localparam logic [CW-1:0] OneC       = CW'(1);
  localparam logic [CW-1:0] MaxTermsC  = CW'(MAX_TERMS);

  psum_state_e       state_q, state_d;
  logic [OWIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]     term_cnt_q, term_cnt_d;
  logic [CW-1:0]     tgt_q, tgt_d;
  logic              out_valid_q, out_valid_d;
  logic [OWIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]     out_count_q, out_count_d;
  logic              sat_q, sat_d;
  logic              out_sat_q, out_sat_d;

  logic              in_fire, out_fire;
  logic [CW-1:0]     tgt_eff, cnt_inc;
  logic [OWIDTH-1:0] add_a, add_sum;
  logic              add_ovf;

  logic              do_emit;
  logic [OWIDTH-1:0] emit_data;
  logic [CW-1:0]     emit_count;
  logic              emit_sat;

  // The output slot frees up in the same cycle it is consumed, so a new result may
  // replace the old one without a bubble.
  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign cnt_inc  = term_cnt_q + OneC;

  // A fresh group always starts from zero, independent of any stale accumulator.
  assign add_a = (state_q == StIdle) ? '0 : acc_q;

  always_comb begin
    if (cfg_terms == '0) begin
      tgt_eff = OneC;
    end else if (cfg_terms > MaxTermsC) begin
      tgt_eff = MaxTermsC;
    end else begin
      tgt_eff = cfg_terms;
    end
  end

  psum_sat_add #(
    .DWIDTH(DWIDTH),
    .OWIDTH(OWIDTH)
  ) u_add (
    .a_i  (add_a),
    .b_i  (in_data),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    term_cnt_d  = term_cnt_q;
    tgt_d       = tgt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    do_emit     = 1'b0;
    emit_data   = add_sum;
    emit_count  = OneC;
    emit_sat    = add_ovf;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          if (tgt_eff == OneC || flush) begin
            do_emit = 1'b1;
          end else begin
            state_d    = StAccum;
            acc_d      = add_sum;
            term_cnt_d = OneC;
            tgt_d      = tgt_eff;
            sat_d      = add_ovf;
          end
        end
      end
      StAccum: begin
        if (in_fire) begin
          if (cnt_inc == tgt_q || flush) begin
            do_emit    = 1'b1;
            emit_count = cnt_inc;
            emit_sat   = sat_q | add_ovf;
          end else begin
            acc_d      = add_sum;
            term_cnt_d = cnt_inc;
            sat_d      = sat_q | add_ovf;
          end
        end else if (flush && in_ready) begin
          // A bare flush waits while a held result blocks the output slot.
          do_emit    = 1'b1;
          emit_data  = acc_q;
          emit_count = term_cnt_q;
          emit_sat   = sat_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_emit) begin
      out_data_d  = emit_data;
      out_count_d = emit_count;
      out_sat_d   = emit_sat;
      out_valid_d = 1'b1;
      acc_d       = '0;
      term_cnt_d  = '0;
      sat_d       = 1'b0;
      state_d     = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      term_cnt_q  <= '0;
      tgt_q       <= OneC;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      term_cnt_q  <= term_cnt_d;
      tgt_q       <= tgt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

`ifdef PSUM_SAT_EN
  assign out_sat = out_sat_q;
`else
  logic unused_out_sat;
  assign unused_out_sat = out_sat_q;
`endif

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with hand-computed expected values.
module tb_psum_accumulator;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic [CW-1:0] cfg_terms;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [CW-1:0] out_count;
`ifdef PSUM_SAT_EN
  logic          out_sat;
`endif

  int n_checks = 0;
  int n_errors = 0;

  psum_accumulator #(
    .DWIDTH   (8),
    .OWIDTH   (8),
    .MAX_TERMS(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_terms(cfg_terms),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
`ifdef PSUM_SAT_EN
    .out_sat  (out_sat),
`endif
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int data, input int count);
    check_eq({tag, "_valid"}, 32'(out_valid), 1);
    check_eq({tag, "_data"}, 32'(out_data), 32'(data));
    check_eq({tag, "_count"}, 32'(out_count), 32'(count));
  endtask

  initial begin
    reset     = 1'b1;
    cfg_terms = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_data", 32'(out_data), 0);
    check_eq("rst_count", 32'(out_count), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);

    // Three-term group, result one clock after the closing term.
    cfg_terms = 4'd3;
    send(8'd10);
    send(8'd20);
    in_valid = 1'b1;
    in_data  = 8'd30;
    check_eq("g3_not_early", 32'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    expect_result("g3", 60, 3);
    tick();
    check_eq("g3_drop", 32'(out_valid), 0);

    // Two-term overflow.
    cfg_terms = 4'd2;
    send(8'd200);
    send(8'd100);
`ifdef PSUM_SAT_EN
    expect_result("sat", 255, 2);
    check_eq("sat_flag", 32'(out_sat), 1);
`else
    expect_result("wrap", 44, 2);
`endif
    tick();

    // Flush on an idle cycle while accumulating.
    cfg_terms = 4'd4;
    send(8'd5);
    send(8'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_result("flush_idle", 11, 2);
    tick();

    // Flush together with an accepted term.
    send(8'd1);
    flush = 1'b1;
    send(8'd2);
    flush = 1'b0;
    expect_result("flush_term", 3, 2);
    tick();

    // Flush on the first term of a group.
    flush = 1'b1;
    send(8'd9);
    flush = 1'b0;
    expect_result("flush_first", 9, 1);
    tick();

    // Flush with nothing held is ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check_eq("flush_noop", 32'(out_valid), 0);

    // cfg_terms = 0 acts as 1; back-to-back single-term groups.
    cfg_terms = 4'd0;
    send(8'd7);
    expect_result("one_a", 7, 1);
    send(8'd9);
    expect_result("one_b", 9, 1);
    tick();

    // Oversized cfg_terms clamps to 8; a mid-group change is ignored.
    cfg_terms = 4'd15;
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) cfg_terms = 4'd2;
      if (i == 8) check_eq("clamp_not_early", 32'(out_valid), 0);
      send(8'(i));
    end
    expect_result("clamp", 36, 8);
    tick();

    // Backpressure: result held, input blocked, then simultaneous transfers.
    cfg_terms = 4'd1;
    out_ready = 1'b0;
    send(8'd42);
    in_valid = 1'b1;
    in_data  = 8'd50;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_in_ready", 32'(in_ready), 0);
      check_eq("bp_data", 32'(out_data), 42);
      check_eq("bp_valid", 32'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    expect_result("bp_next", 50, 1);
    tick();
    check_eq("bp_drop", 32'(out_valid), 0);

    // Reset mid-group discards the partial sum.
    cfg_terms = 4'd4;
    send(8'd100);
    send(8'd100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_valid", 32'(out_valid), 0);
    tick();
    check_eq("mid_rst_idle", 32'(out_valid), 0);
    cfg_terms = 4'd2;
    send(8'd3);
    send(8'd4);
    expect_result("post_rst", 7, 2);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
